// File: rtl/atseq_pkg.sv
// Shared definitions for the adaptive threshold sequencer: FSM state encoding and binary output levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atseq_pkg;

  localparam int PHASE_W = 3;

  // Encoding is visible on oPhase, so the values are fixed.
  typedef enum logic [PHASE_W-1:0] {
    IDLE   = 3'd0,
    FRST   = 3'd1,
    FILTER = 3'd2,
    THRESH = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] BIN_HI = 8'hFF;
  localparam logic [7:0] BIN_LO = 8'h00;

endpackage

// File: rtl/adaptive_threshold_sequencer_bin_compare.sv
// Combinational binarisation of one pixel against (local mean - offset).
// Latency: 0 cycles (pure combinational; the parent registers the result).
// Backpressure: none.
//   pixel  in  8  source image pixel
//   mean   in  8  local 3x3 mean at the same position
//   offset in  8  threshold offset C
//   result out 8  BIN_HI when pixel > mean - offset, else BIN_LO
module bin_compare
  import atseq_pkg::*;
(
  input  logic [7:0] pixel,
  input  logic [7:0] mean,
  input  logic [7:0] offset,
  output logic [7:0] result
);

  // 10-bit signed arithmetic: mean - offset may go negative, in which case
  // every pixel lies above the threshold.
  logic signed [9:0] pixel_s;
  logic signed [9:0] thresh_s;

  assign pixel_s  = $signed({2'b00, pixel});
  assign thresh_s = $signed({2'b00, mean}) - $signed({2'b00, offset});
  assign result   = (pixel_s > thresh_s) ? BIN_HI : BIN_LO;

endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// Run controller: resets/launches the box-filter engine, then runs a one-pixel-per-cycle threshold pass.
// Latency: threshold result written 1 cycle after its read address; pass is WIDTH*HEIGHT cycles + 1 drain.
// Backpressure: none; memories are async-read and always accept writes, iStart is ignored while busy.
//   clock/reset            clock, synchronous active-low reset
//   iStart/iOffset         run request and threshold offset (sampled in IDLE/DONE)
//   oBusy/oDone/oError     run status; oError is sticky for a filter timeout in the last run
//   oPhase                 current FSM state
//   oFilterReset           held high except while the filter engine runs
//   iFilterFinished/Col/Row filter engine status and image address
//   oImageCol/Row, iImageData  image memory read port (muxed filter engine / threshold pass)
//   oMeanCol/Row, iMeanData    mean memory read port
//   oBinCol/Row/Data/Wren      binary image write port
// Build option: ATSEQ_AUTO_RESTART_EN restarts a new frame from DONE unless the last run timed out.
module adaptive_threshold_sequencer
  import atseq_pkg::*;
#(
  parameter int WIDTH_BITS     = 7,
  parameter int HEIGHT_BITS    = 7,
  parameter int FILTER_TIMEOUT = 10 * (2**WIDTH_BITS) * (2**HEIGHT_BITS) + 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  input  logic [7:0]             iOffset,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [2:0]             oPhase,
  output logic                   oFilterReset,
  input  logic                   iFilterFinished,
  input  logic [WIDTH_BITS-1:0]  iFilterCol,
  input  logic [HEIGHT_BITS-1:0] iFilterRow,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oBinCol,
  output logic [HEIGHT_BITS-1:0] oBinRow,
  output logic [7:0]             oBinData,
  output logic                   oBinWren
);

  localparam int POS_W   = WIDTH_BITS + HEIGHT_BITS;
  localparam int TIMER_W = $clog2(FILTER_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(FILTER_TIMEOUT - 1);

`ifdef ATSEQ_AUTO_RESTART_EN
  localparam bit AUTO_RESTART = 1'b1;
`else
  localparam bit AUTO_RESTART = 1'b0;
`endif

  state_t             state;
  logic [POS_W-1:0]   pos;
  logic [TIMER_W-1:0] timer;
  logic [7:0]         offset_q;
  logic [7:0]         cmp_result;

  logic [WIDTH_BITS-1:0]  pos_col;
  logic [HEIGHT_BITS-1:0] pos_row;

  // pos scans row-major: column is the low field.
  assign pos_col = pos[WIDTH_BITS-1:0];
  assign pos_row = pos[POS_W-1:WIDTH_BITS];

  // The filter engine owns the image read port only while it is running.
  assign oImageCol = (state == FILTER) ? iFilterCol : pos_col;
  assign oImageRow = (state == FILTER) ? iFilterRow : pos_row;
  assign oMeanCol  = pos_col;
  assign oMeanRow  = pos_row;
  assign oPhase    = state;

  bin_compare u_bin_compare (
    .pixel  (iImageData),
    .mean   (iMeanData),
    .offset (offset_q),
    .result (cmp_result)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      pos          <= '0;
      timer        <= '0;
      offset_q     <= '0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oFilterReset <= 1'b1;
      oBinWren     <= 1'b0;
      oBinData     <= BIN_LO;
      oBinCol      <= '0;
      oBinRow      <= '0;
    end else begin
      oDone    <= 1'b0;
      oBinWren <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state    <= FRST;
            oBusy    <= 1'b1;
            oError   <= 1'b0;
            offset_q <= iOffset;
          end
        end
        FRST: begin
          state        <= FILTER;
          timer        <= '0;
          oFilterReset <= 1'b0;
        end
        FILTER: begin
          if (timer != '1) timer <= timer + TIMER_W'(1);
          // Timeout wins over a simultaneous finish.
          if (timer == TIMEOUT_LAST) begin
            state        <= DONE;
            oError       <= 1'b1;
            oDone        <= 1'b1;
            oBusy        <= 1'b0;
            oFilterReset <= 1'b1;
          end else if (iFilterFinished) begin
            state        <= THRESH;
            pos          <= '0;
            oFilterReset <= 1'b1;
          end
        end
        THRESH: begin
          // Register the compare for the address presented this cycle.
          oBinWren <= 1'b1;
          oBinCol  <= pos_col;
          oBinRow  <= pos_row;
          oBinData <= cmp_result;
          if (pos == '1) begin
            state <= DONE;
            oDone <= 1'b1;
            oBusy <= 1'b0;
          end else begin
            pos <= pos + POS_W'(1);
          end
        end
        DONE: begin
          if (iStart || (AUTO_RESTART && !oError)) begin
            state    <= FRST;
            oBusy    <= 1'b1;
            oError   <= 1'b0;
            offset_q <= iOffset;
          end
        end
        default: begin
          state        <= IDLE;
          oBusy        <= 1'b0;
          oFilterReset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// Bench for adaptive_threshold_sequencer on a 4x4 image with a behavioural box-filter engine.
// Expected binary writes are queued when a run is launched; a negedge monitor pops and compares them.
// Summary line reports total comparisons and failures.
module tb_adaptive_threshold_sequencer;
  import atseq_pkg::*;

  localparam int WB      = 2;
  localparam int HB      = 2;
  localparam int NPIX    = 16;
  localparam int TIMEOUT = 10 * NPIX + 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iStart = 1'b0;
  logic [7:0]    iOffset = 8'd0;
  logic          oBusy, oDone, oError, oFilterReset, oBinWren;
  logic [2:0]    oPhase;
  logic          iFilterFinished = 1'b0;
  logic [WB-1:0] iFilterCol = '0;
  logic [HB-1:0] iFilterRow = '0;
  logic [WB-1:0] oImageCol, oMeanCol, oBinCol;
  logic [HB-1:0] oImageRow, oMeanRow, oBinRow;
  logic [7:0]    iImageData, iMeanData, oBinData;

  always #5 clock = ~clock;

  adaptive_threshold_sequencer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
    .clock(clock), .reset(reset), .iStart(iStart), .iOffset(iOffset),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oPhase(oPhase),
    .oFilterReset(oFilterReset), .iFilterFinished(iFilterFinished),
    .iFilterCol(iFilterCol), .iFilterRow(iFilterRow),
    .oImageCol(oImageCol), .oImageRow(oImageRow), .iImageData(iImageData),
    .oMeanCol(oMeanCol), .oMeanRow(oMeanRow), .iMeanData(iMeanData),
    .oBinCol(oBinCol), .oBinRow(oBinRow), .oBinData(oBinData), .oBinWren(oBinWren)
  );

  logic [7:0] img      [NPIX];
  logic [7:0] mean_mem [NPIX];
  assign iImageData = img[{oImageRow, oImageCol}];
  assign iMeanData  = mean_mem[{oMeanRow, oMeanCol}];

  typedef struct { logic [3:0] addr; logic [7:0] data; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, wr_cnt = 0, filt_cyc = 0, thr_cyc = 0;
  bit hang = 1'b0;
  int f_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // 3x3 mean with edge clipping (average of the in-bounds neighbours).
  function automatic int box_mean(input int p);
    int r, c, sum, n;
    r = p / 4; c = p % 4; sum = 0; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < 4 && c + dc >= 0 && c + dc < 4) begin
          sum += int'(img[(r + dr) * 4 + c + dc]);
          n++;
        end
    return sum / n;
  endfunction

  // Filter engine model: sweeps the image address, then publishes the mean image and finishes.
  always @(negedge clock) begin
    if (oFilterReset) begin
      f_cnt = 0;
      iFilterFinished = 1'b0;
      iFilterCol = '0;
      iFilterRow = '0;
    end else if (!hang && f_cnt < NPIX) begin
      iFilterCol = f_cnt[1:0];
      iFilterRow = f_cnt[3:2];
      f_cnt++;
      if (f_cnt == NPIX) begin
        for (int p = 0; p < NPIX; p++) mean_mem[p] = 8'(box_mean(p));
        iFilterFinished = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clock) begin
    if (oDone) done_cnt++;
    if (oPhase == FILTER) filt_cyc++;
    if (oPhase == THRESH) thr_cyc++;
    if (oBinWren) begin
      wr_cnt++;
      check("wren_window", 32'(oPhase == THRESH || oPhase == DONE), 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with no write expected", {oBinRow, oBinCol}, oBinData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin_addr", 32'({oBinRow, oBinCol}), 32'(e.addr));
        check("bin_data", 32'(oBinData), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_expected(input logic [7:0] c, input int n);
    exp_t e;
    for (int p = 0; p < n; p++) begin
      e.addr = 4'(p);
      e.data = (int'(img[p]) > box_mean(p) - int'(c)) ? 8'hFF : 8'h00;
      sb.push_back(e);
    end
  endtask

  // Launch a run; checks the 1-cycle FRST and that iStart during FILTER is ignored.
  task automatic run_frame(input logic [7:0] c, input bit h, input int n_exp);
    hang = h;
    iOffset = c;
    push_expected(c, n_exp);
    done_cnt = 0; wr_cnt = 0; filt_cyc = 0; thr_cyc = 0;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    check("frst_phase", 32'(oPhase), 32'(FRST));
    check("frst_busy", 32'(oBusy), 32'd1);
    check("frst_error_clr", 32'(oError), 32'd0);
    check("frst_freset", 32'(oFilterReset), 32'd1);
    step();
    check("filter_phase", 32'(oPhase), 32'(FILTER));
    check("filter_freset", 32'(oFilterReset), 32'd0);
    iStart = 1'b1;
    iOffset = ~c;
    step();
    iStart = 1'b0;
    iOffset = c;
    check("start_ignored_phase", 32'(oPhase), 32'(FILTER));
    check("start_ignored_busy", 32'(oBusy), 32'd1);
    check("filter_addr_mux", 32'({oImageRow, oImageCol}), 32'({iFilterRow, iFilterCol}));
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!oDone && i < limit) begin
      step();
      i++;
    end
    check("done_seen", 32'(oDone), 32'd1);
    check("done_phase", 32'(oPhase), 32'(DONE));
    check("done_busy", 32'(oBusy), 32'd0);
  endtask

  // Stop continuous frame mode so the next directed run starts from a known state.
  task automatic stop_auto();
`ifdef ATSEQ_AUTO_RESTART_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
`endif
  endtask

  task automatic normal_run(input logic [7:0] c);
    run_frame(c, 1'b0, NPIX);
    wait_done(200);
    check("thresh_cycles", 32'(thr_cyc), 32'(NPIX));
    check("run_error", 32'(oError), 32'd0);
    stop_auto();
    step();
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(NPIX));
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // 1. reset
    reset = 1'b0;
    step();
    step();
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_wren", 32'(oBinWren), 32'd0);
    check("rst_freset", 32'(oFilterReset), 32'd1);
    check("rst_phase", 32'(oPhase), 32'(IDLE));
    reset = 1'b1;
    step();
    check("idle_phase", 32'(oPhase), 32'(IDLE));
    check("idle_done", 32'(oDone), 32'd0);
    check("idle_error", 32'(oError), 32'd0);
    check("idle_data", 32'(oBinData), 32'd0);

    // 2. flat 100, C=5: 100 > 95, all 8'hFF
    for (int p = 0; p < NPIX; p++) img[p] = 8'd100;
    normal_run(8'd5);

    // 3. flat 3: C=10 gives negative threshold (all FF); C=0 gives 3 > 3 false (all 00)
    for (int p = 0; p < NPIX; p++) img[p] = 8'd3;
    normal_run(8'd10);
    normal_run(8'd0);

    // checkerboard 200/10 with C=20: mixed result
    for (int p = 0; p < NPIX; p++) img[p] = (((p % 4) + (p / 4)) % 2 == 1) ? 8'd200 : 8'd10;
    normal_run(8'd20);

    // 4. filter never finishes: timeout, error, no writes
    run_frame(8'd5, 1'b1, 0);
    wait_done(TIMEOUT + 50);
    check("timeout_error", 32'(oError), 32'd1);
    check("timeout_filter_cycles", 32'(filt_cyc), 32'(TIMEOUT));
    check("timeout_writes", 32'(wr_cnt), 32'd0);
    stop_auto();

    // 5. reset in THRESH at pos=7: writes 0..6 only
    for (int p = 0; p < NPIX; p++) img[p] = 8'(p * 15);
    run_frame(8'd0, 1'b0, 7);
    k = 0;
    while (!(oPhase == THRESH && {oImageRow, oImageCol} == 4'd7) && k < 100) begin
      step();
      k++;
    end
    check("reached_pos7", 32'(oPhase == THRESH && {oImageRow, oImageCol} == 4'd7), 32'd1);
    reset = 1'b0;
    step();
    check("abort_phase", 32'(oPhase), 32'(IDLE));
    check("abort_wren", 32'(oBinWren), 32'd0);
    check("abort_busy", 32'(oBusy), 32'd0);
    reset = 1'b1;
    step();
    step();
    step();
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    check("abort_writes", 32'(wr_cnt), 32'd7);

    // 6. frame chaining behaviour after DONE
    for (int p = 0; p < NPIX; p++) img[p] = 8'd100;
`ifdef ATSEQ_AUTO_RESTART_EN
    run_frame(8'd5, 1'b0, 2 * NPIX);
    wait_done(200);
    step();
    wait_done(200);
    check("auto_done_pulses", 32'(done_cnt), 32'd2);
    stop_auto();
    step();
    check("auto_sb_empty", 32'(sb.size()), 32'd0);
    check("auto_writes", 32'(wr_cnt), 32'(2 * NPIX));
`else
    run_frame(8'd5, 1'b0, NPIX);
    wait_done(200);
    for (int i = 0; i < 20; i++) step();
    check("hold_phase", 32'(oPhase), 32'(DONE));
    check("hold_done_pulses", 32'(done_cnt), 32'd1);
    check("hold_busy", 32'(oBusy), 32'd0);
    check("hold_sb_empty", 32'(sb.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
